// File: rtl/serial_rom_arbiter.sv
// Two-requester arbiter in front of a bit-serial ROM: one read at a time, DATA_W bits shifted LSB first.
// Define SRA_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module serial_rom_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  output logic              rom_start,
  input  logic              rom_bit,
  output logic              busy
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-2:0] shift_q;
  logic              owner_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              rom_cs_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q;
  logic [DATA_W-1:0] rsp1_data_q;
  logic              grant0_d;
  logic              grant1_d;
  logic [DATA_W-1:0] word_d;
`ifndef SRA_FIXED_PRIO_EN
  logic              last_grant_q;
`endif

  // Incoming bit joins the bits already shifted in; complete once cnt reaches DATA_W.
  assign word_d = {rom_bit, shift_q};

  // Grant decision, only while IDLE and out of reset.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (req0_valid && req1_valid) begin
`ifdef SRA_FIXED_PRIO_EN
        grant0_d = 1'b1;
        grant1_d = 1'b0;
`else
        grant0_d = last_grant_q;
        grant1_d = ~last_grant_q;
`endif
      end else begin
        grant0_d = req0_valid;
        grant1_d = req1_valid;
      end
    end else begin
      grant0_d = 1'b0;
      grant1_d = 1'b0;
    end
  end

  // Transfer FSM with all externally visible controls registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      shift_q      <= {(DATA_W-1){1'b0}};
      owner_q      <= 1'b0;
      rom_addr_q   <= {ADDR_W{1'b0}};
      rom_cs_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= {DATA_W{1'b0}};
      rsp1_data_q  <= {DATA_W{1'b0}};
`ifndef SRA_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            rom_addr_q <= grant1_d ? req1_addr : req0_addr;
            owner_q    <= grant1_d;
            cnt_q      <= CNT_ZERO;
            shift_q    <= {(DATA_W-1){1'b0}};
            rom_cs_q   <= 1'b1;
            state_q    <= XFER;
`ifndef SRA_FIXED_PRIO_EN
            last_grant_q <= grant1_d;
`endif
          end
        end
        XFER: begin
          // Bit k arrives one cycle after the k-th enabled cycle, so capture lags cnt by one.
          if (cnt_q != CNT_ZERO) begin
            shift_q <= word_d[DATA_W-1:1];
          end
          if (cnt_q == (CNT_LAST - CNT_ONE)) begin
            rom_cs_q <= 1'b0;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            state_q <= DONE;
            if (owner_q) begin
              rsp1_valid_q <= 1'b1;
              rsp1_data_q  <= word_d;
            end else begin
              rsp0_valid_q <= 1'b1;
              rsp0_data_q  <= word_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          rom_cs_q <= 1'b0;
          cnt_q    <= CNT_ZERO;
        end
      endcase
    end
  end

  assign req0_ready = grant0_d;
  assign req1_ready = grant1_d;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign rom_addr   = rom_addr_q;
  assign rom_cs     = rom_cs_q;
  assign rom_start  = rom_cs_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rom_arbiter.sv
// Bench for serial_rom_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level timing model and a behavioural serial ROM.
module tb_serial_rom_arbiter;
  localparam int DW = 4;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_addr, req1_addr;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid;
  logic [3:0] rsp0_data, rsp1_data;
  logic [3:0] rom_addr;
  logic       rom_cs, rom_start, rom_bit, busy;

  serial_rom_arbiter #(.ADDR_W(4), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_start(rom_start),
    .rom_bit(rom_bit), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] rom_mem [16];
  logic [1:0] rk;

  // Model: a transfer accepted at the end of cycle acc occupies cycles acc+1..acc+DW+2.
  int         acc;
  bit         own, last_g, hold0, hold1, seen0;
  logic [3:0] word_e, d0_e, d1_e, ra_e;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    acc = -1; own = 1'b0; last_g = 1'b1;
    d0_e = 4'h0; d1_e = 4'h0; ra_e = 4'h0; word_e = 4'h0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then play the ROM.
  task automatic step();
    bit b_e, cs_e, rv_e, g0, g1, pcs;
    logic [3:0] pa;
    #1;
    b_e  = (acc >= 0) && (cyc > acc) && (cyc <= acc + DW + 2);
    cs_e = (acc >= 0) && (cyc > acc) && (cyc <= acc + DW);
    rv_e = (acc >= 0) && (cyc == acc + DW + 2);
    if (rv_e) begin
      if (own) d1_e = word_e;
      else     d0_e = word_e;
    end
    g0 = 1'b0; g1 = 1'b0;
    if (rst_n && !b_e) begin
      if (req0_valid && req1_valid) begin
`ifdef SRA_FIXED_PRIO_EN
        g0 = 1'b1;
`else
        g0 = last_g; g1 = !last_g;
`endif
      end else begin
        g0 = req0_valid; g1 = req1_valid;
      end
    end
    chk1("req0_ready", req0_ready, g0);
    chk1("req1_ready", req1_ready, g1);
    chk1("rom_cs", rom_cs, cs_e);
    chk1("rom_start", rom_start, rom_cs);
    chk1("busy", busy, b_e);
    chk1("rsp0_valid", rsp0_valid, rv_e && !own);
    chk1("rsp1_valid", rsp1_valid, rv_e && own);
    chk4("rsp0_data", rsp0_data, d0_e);
    chk4("rsp1_data", rsp1_data, d1_e);
    chk4("rom_addr", rom_addr, ra_e);
    if (req0_ready && req0_valid) seen0 = 1'b1;
    if (g0 || g1) begin
      acc = cyc; own = g1; last_g = g1;
      ra_e = g1 ? req1_addr : req0_addr;
      word_e = rom_mem[ra_e];
    end
    pcs = rom_cs; pa = rom_addr;
    @(posedge clk); #1;
    cyc++;
    if (g0 && !hold0) req0_valid = 1'b0;
    if (g1 && !hold1) req1_valid = 1'b0;
    if (pcs) begin
      rom_bit = rom_mem[pa][rk];
      rk = rk + 2'd1;
    end else begin
      rom_bit = 1'b0;
      rk = 2'd0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_acc0();
    int n;
    n = 0;
    seen0 = 1'b0;
    while (!seen0 && n < 20) begin
      step();
      n++;
    end
    chk1("acc0_wait", seen0, 1'b1);
  endtask

  task automatic drive_random();
    if (!req0_valid) begin
      if ($urandom_range(0, 3) == 0) begin req0_valid = 1'b1; req0_addr = 4'($urandom); end
    end else if ($urandom_range(0, 19) == 0) begin
      req0_valid = 1'b0;
    end
    if (!req1_valid) begin
      if ($urandom_range(0, 3) == 0) begin req1_valid = 1'b1; req1_addr = 4'($urandom); end
    end else if ($urandom_range(0, 19) == 0) begin
      req1_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 4'h0; req1_addr = 4'h0; rom_bit = 1'b0; rk = 2'd0;
    hold0 = 1'b0; hold1 = 1'b0; seen0 = 1'b0;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'(i);
    model_reset();
    @(posedge clk); #1;
    run(2);
    rst_n = 1'b1;
    step();

    // Single request from requester 0
    req0_valid = 1'b1; req0_addr = 4'h5;
    run(12);

    // Both requesters held: alternating grants
    req0_valid = 1'b1; req0_addr = 4'h3;
    req1_valid = 1'b1; req1_addr = 4'hC;
    hold0 = 1'b1; hold1 = 1'b1;
    run(4 * (DW + 3));
    hold0 = 1'b0; hold1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    run(10);

    // Requester 1 arrives while requester 0 is transferring
    req0_valid = 1'b1; req0_addr = 4'h7;
    wait_acc0();
    run(2);
    req1_valid = 1'b1; req1_addr = 4'hA;
    run(16);

    // Reset in the second transfer cycle
    req0_valid = 1'b1; req0_addr = 4'h3;
    wait_acc0();
    step();
    rst_n = 1'b0;
    #1;
    chk1("rst_rom_cs", rom_cs, 1'b0);
    chk1("rst_rom_start", rom_start, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    model_reset();
    run(2);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 4'hF;
    run(12);

    // Random traffic over random ROM contents
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_rom_arbiter.md
SERIAL_ROM_ARBITER -- requirements
Module: serial_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: ROM address width.
REQ-002 Parameter DATA_W, default 4: ROM word width, i.e. bits shifted per read.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 read request; held until accepted.
REQ-006 req0_addr  input  ADDR_W  requester 0 word address; stable while req0_valid.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-008 rsp0_valid  output  1  one-cycle pulse: rsp0_data valid.
REQ-009 rsp0_data  output  DATA_W  word read for requester 0.
REQ-010 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same directions, widths and meanings as REQ-005..009, for requester 1.
REQ-011 rom_addr  output  ADDR_W  address driven to serial ROM.
REQ-012 rom_cs  output  1  ROM chip select.
REQ-013 rom_start  output  1  ROM shift enable; always equal to rom_cs.
REQ-014 rom_bit  input  1  ROM serial data; bit k of word registered one cycle after k-th enabled cycle, LSB first.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, XFER, DONE, all registered.
REQ-017 IDLE: reqN_ready is combinational, high only for the granted requester with reqN_valid=1; at most one ready high per cycle.
REQ-018 Acceptance (valid & ready) latches reqN_addr into rom_addr, records owner, clears counter cnt to 0, moves to XFER.
REQ-019 Arbitration: round-robin on last_grant; both valid -> grant the one not granted last; one valid -> grant it.
REQ-020 XFER: rom_cs = rom_start = 1 while cnt < DATA_W, 0 when cnt = DATA_W; cnt increments each cycle.
REQ-021 XFER: when cnt >= 1, rom_bit is captured into data bit (cnt-1).
REQ-022 XFER with cnt = DATA_W: capture the final bit, go to DONE.
REQ-023 DONE: rsp_valid of owner high exactly one cycle, rsp_data = assembled word; other rsp_valid low; return to IDLE.
REQ-024 rspN_data holds its last value until the next response to that requester.
REQ-025 Latency: accept at edge T -> rom_cs high for cycles T+1..T+DATA_W -> rspN_valid in cycle T+DATA_W+2; next acceptance no earlier than T+DATA_W+3.
REQ-026 reqN_ready = 0 in XFER and DONE; requests arriving then wait, not dropped.
REQ-027 rom_addr held constant from acceptance until return to IDLE.
REQ-028 Request deasserted before acceptance: withdrawn, no ROM access.

Reset
REQ-029 rst_n low: state IDLE, cnt 0, rom_cs = rom_start = 0, rom_addr 0, all ready/rsp_valid 0, rsp data 0, busy 0, last_grant = 1 (requester 0 wins first tie).
REQ-030 Reset mid-XFER: rom_cs drops immediately, transfer discarded, no response issued.

Configuration
REQ-031 Macro SRA_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins a tie; last_grant unused.
REQ-032 Macro SRA_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification (ROM model: word[i] = i, DATA_W = 4)
REQ-033 req0 addr 0x5 alone -> rom_cs high 4 cycles, rom_addr 0x5, rsp0_valid 6 cycles after acceptance cycle with rsp0_data 0x5.
REQ-034 req0 addr 0x3 and req1 addr 0xC both held -> grant order 0,1,0,1; rsp data 0x3,0xC alternating; never two ready in one cycle.
REQ-035 Same as REQ-034 with SRA_FIXED_PRIO_EN -> req0 served every time, req1 starves while req0 held.
REQ-036 req1 addr 0xA asserted during req0 XFER -> req1_ready low until IDLE, then accepted, rsp1_data 0xA.
REQ-037 rst_n low at 2nd XFER cycle -> rom_cs 0 immediately, no rsp_valid; after release, req0 addr 0xF -> rsp0_data 0xF.
REQ-038 rsp pulse check -> each rspN_valid exactly 1 cycle wide; rom_start equals rom_cs every cycle.
